ultrasonic_scan_scheduler: RTL and testbench

//  Round-robin scheduler for N HC-SR04 rangers that share one timing datapath. It fires one sensor at a time to avoid

---
 rtl/ultrasonic_pkg.sv | 15 +
 rtl/ultrasonic_scan_scheduler_usec_tick.sv | 15 +
 rtl/ultrasonic_scan_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_ultrasonic_scan_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg: shared state encoding and constants for the ultrasonic scan scheduler
package ultrasonic_pkg;
  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    WAIT_FALL,
    CALC,
    REPORT,
    REPORT_TO,
    GAP
  } state_t;
  localparam int US_PER_CM = 58;
  localparam logic [15:0] DIST_TIMEOUT_CODE = 16'hFFFF;
endpackage

// File: rtl/ultrasonic_scan_scheduler_usec_tick.sv
// usec_tick: free-running prescaler producing a one-clock tick every microsecond
module usec_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick
);
  localparam int DIV = (CLK_HZ >= 2_000_000) ? CLK_HZ / 1_000_000 : 1;
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  // count 0..DIV-1, wrapping on the tick
  always_ff @(posedge clk) cnt <= (reset_p || tick) ? '0 : cnt + 1'b1;
  assign tick = cnt == W'(DIV - 1);
endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// ultrasonic_scan_scheduler: round-robin HC-SR04 scheduler sharing one timing/divide datapath; define ULTRASONIC_SCAN_AVG_EN for per-channel two-sample averaging
module ultrasonic_scan_scheduler
  import ultrasonic_pkg::*;
#(
  parameter int N_SENSORS  = 4,
  parameter int CLK_HZ     = 100_000_000,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 23_201,
  parameter int GAP_US     = 60_000,
  localparam int CW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_p,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] channel_mask,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trigger,
  output logic                 busy,
  output logic [CW-1:0]        cur_ch,
  output logic                 dist_valid,
  output logic [CW-1:0]        dist_ch,
  output logic [15:0]          dist_cm,
  output logic                 dist_timeout
);
  localparam int TW = $clog2(TRIG_US + 1);
  localparam int UW = $clog2(TIMEOUT_US + 1);
  localparam int GW = $clog2(GAP_US + 1);
  state_t state;
  logic tick;
  logic [N_SENSORS-1:0] s1, s2, s3;
  logic rise, fall, timed_out, found;
  logic [CW-1:0] next_ch, idx;
  logic [TW-1:0] tcnt;
  logic [UW-1:0] us_cnt;
  logic [GW-1:0] gcnt;
  logic [15:0] width, rem, q, res_cm;
`ifdef ULTRASONIC_SCAN_AVG_EN
  logic [15:0] hist [N_SENSORS];
  logic [N_SENSORS-1:0] hist_ok;
  logic [15:0] avg_q;
  logic avg_step;
  assign res_cm = avg_q;
`else
  assign res_cm = q;
`endif
  usec_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk(clk),
    .reset_p(reset_p),
    .tick(tick)
  );
  // two-flop synchronizer plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (reset_p) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= echo;
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign rise = s2[cur_ch] & ~s3[cur_ch];
  assign fall = ~s2[cur_ch] & s3[cur_ch];
  assign timed_out = us_cnt >= UW'(TIMEOUT_US);
  // next masked channel strictly after cur_ch, wrapping; cur_ch itself is the last candidate
  always_comb begin
    next_ch = cur_ch;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= N_SENSORS; i++) begin
      idx = CW'((int'(cur_ch) + i) % N_SENSORS);
      if (!found && channel_mask[idx]) begin
        next_ch = idx;
        found = 1'b1;
      end
    end
  end
  // scan FSM: trigger, echo timing, divide by 58, report, quiet gap
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state <= IDLE;
      cur_ch <= CW'(N_SENSORS - 1);
      trigger <= '0;
      busy <= 1'b0;
      dist_valid <= 1'b0;
      dist_ch <= '0;
      dist_cm <= '0;
      dist_timeout <= 1'b0;
      tcnt <= '0;
      us_cnt <= '0;
      gcnt <= '0;
      width <= '0;
      rem <= '0;
      q <= '0;
`ifdef ULTRASONIC_SCAN_AVG_EN
      hist <= '{default: '0};
      hist_ok <= '0;
      avg_q <= '0;
      avg_step <= 1'b0;
`endif
    end else if (!enable) begin
      state <= IDLE;
      trigger <= '0;
      busy <= 1'b0;
      dist_valid <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      case (state)
        IDLE: if (|channel_mask) begin
          cur_ch <= next_ch;
          trigger <= N_SENSORS'(1) << next_ch;
          busy <= 1'b1;
          tcnt <= '0;
          state <= TRIG;
        end
        TRIG: if (tick) begin
          tcnt <= tcnt + 1'b1;
          if (tcnt == TW'(TRIG_US - 1)) begin
            trigger <= '0;
            us_cnt <= '0;
            state <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (tick && !timed_out) us_cnt <= us_cnt + 1'b1;
          if (rise) begin
            width <= '0;
            state <= WAIT_FALL;
          end else if (timed_out) state <= REPORT_TO;
        end
        WAIT_FALL: begin
          if (tick && !timed_out) us_cnt <= us_cnt + 1'b1;
          if (tick && width != '1) width <= width + 1'b1;
          if (fall) begin
            rem <= (tick && width != '1) ? width + 1'b1 : width;
            q <= '0;
`ifdef ULTRASONIC_SCAN_AVG_EN
            avg_step <= 1'b0;
`endif
            state <= CALC;
          end else if (timed_out) state <= REPORT_TO;
        end
        CALC: if (rem >= 16'(US_PER_CM)) begin
          rem <= rem - 16'(US_PER_CM);
          q <= q + 1'b1;
        end
`ifdef ULTRASONIC_SCAN_AVG_EN
        else if (!avg_step) begin
          avg_q <= hist_ok[cur_ch] ? 16'((17'(q) + 17'(hist[cur_ch])) >> 1) : q;
          hist[cur_ch] <= q;
          hist_ok[cur_ch] <= 1'b1;
          avg_step <= 1'b1;
        end
`endif
        else state <= REPORT;
        REPORT: begin
          dist_valid <= 1'b1;
          dist_ch <= cur_ch;
          dist_cm <= res_cm;
          dist_timeout <= 1'b0;
          gcnt <= '0;
          state <= GAP;
        end
        REPORT_TO: begin
          dist_valid <= 1'b1;
          dist_ch <= cur_ch;
          dist_cm <= DIST_TIMEOUT_CODE;
          dist_timeout <= 1'b1;
          gcnt <= '0;
`ifdef ULTRASONIC_SCAN_AVG_EN
          hist_ok[cur_ch] <= 1'b0;
`endif
          state <= GAP;
        end
        GAP: if (tick) begin
          gcnt <= gcnt + 1'b1;
          if (gcnt == GW'(GAP_US - 1)) begin
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// tb_ultrasonic_scan_scheduler: table-driven and randomized checks of the scan scheduler against a measurement-level model
module tb_ultrasonic_scan_scheduler;
`ifdef ULTRASONIC_SCAN_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif
  localparam int TO_US = 23_201;
  logic clk = 1'b0;
  logic reset_p, enable;
  logic [3:0] channel_mask, echo, trigger;
  logic busy, dist_valid, dist_timeout;
  logic [1:0] cur_ch, dist_ch;
  logic [15:0] dist_cm;
  int n_checks = 0, n_fail = 0;
  int width [4];
  logic [3:0] hold = '0;
  int delay = 40;
  int cyc = 0, last_ch = 3, pending = 0, m_ch = 0, m_w = 0, t_dv = -1, t_fall = 0, tlen = 0;
  int hist_m [4];
  bit hv_m [4];
  logic [3:0] ptrig = '0;
  typedef struct {
    logic [3:0] mask;
    int ch;
    bit hold;
    int w;
    int cm;
    bit to;
  } vec_t;
  vec_t vec [14];
  ultrasonic_scan_scheduler #(
    .N_SENSORS(4), .CLK_HZ(1_000_000), .TRIG_US(10), .TIMEOUT_US(TO_US), .GAP_US(100)
  ) dut (
    .clk(clk), .reset_p(reset_p), .enable(enable), .channel_mask(channel_mask), .echo(echo),
    .trigger(trigger), .busy(busy), .cur_ch(cur_ch), .dist_valid(dist_valid),
    .dist_ch(dist_ch), .dist_cm(dist_cm), .dist_timeout(dist_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask
  function automatic int ch_of(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction
  function automatic int next_m(int last, logic [3:0] m);
    for (int i = 1; i <= 4; i++) if (m[(last + i) % 4]) return (last + i) % 4;
    return -1;
  endfunction
  task automatic wait_dv(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30000 && !ok; k++) begin
      @(negedge clk);
      ok = dist_valid;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL dv_wait: no dist_valid within 30000 clk");
    end
  endtask
  // sensor model: after trigger[c] falls, wait delay clocks then hold echo[c] high for width[c] clocks
  initial begin
    int t, rc;
    logic [3:0] pt, e;
    echo = '0;
    rc = -1;
    t = 0;
    pt = '0;
    forever begin
      @(negedge clk);
      if (trigger != 0) rc = -1;
      else if (pt != 0) begin
        rc = ch_of(pt);
        t = 0;
      end
      t++;
      e = hold;
      if (rc >= 0 && width[rc] > 0 && t > delay && t <= delay + width[rc]) e[rc] = 1'b1;
      echo = e;
      pt = trigger;
    end
  end
  // scoreboard: channel order, trigger length, gap, result values and timeout latency
  always @(negedge clk) begin
    int tc, q, ecm;
    cyc++;
    if (!reset_p) begin
      if (trigger != 0 && ptrig == 0) begin
        tc = ch_of(trigger);
        chk("trig_onehot", int'($onehot(trigger)), 1);
        chk("trig_order", tc, next_m(last_ch, channel_mask));
        if (t_dv >= 0) chk_rng("gap_len", cyc - t_dv, 100, 103);
        t_dv = -1;
        last_ch = tc;
        tlen = 0;
        m_ch = tc;
        m_w = (hold[tc] || width[tc] == 0 || delay + width[tc] >= TO_US) ? 0 : width[tc];
        pending = 1;
      end
      if (trigger != 0) tlen++;
      if (trigger == 0 && ptrig != 0 && enable) begin
        chk("trig_len", tlen, 10);
        t_fall = cyc;
      end
      if (dist_valid) begin
        if (pending == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_dv: got dist_valid ch %0d, expected none", dist_ch);
        end else begin
          if (m_w == 0) begin
            ecm = 16'hFFFF;
            hv_m[m_ch] = 1'b0;
            chk_rng("to_latency", cyc - t_fall, TO_US, TO_US + 5);
          end else begin
            q = m_w / 58;
            ecm = (AVG && hv_m[m_ch]) ? (q + hist_m[m_ch]) / 2 : q;
            hist_m[m_ch] = q;
            hv_m[m_ch] = 1'b1;
          end
          chk("model_ch", int'(dist_ch), m_ch);
          chk("model_cm", int'(dist_cm), ecm);
          chk("model_to", int'(dist_timeout), int'(m_w == 0));
          pending = 0;
          t_dv = cyc;
        end
      end
      ptrig = trigger;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    bit ok;
    int ndv;
    vec[0]  = '{4'b1111, 0, 1'b0, 580,  10, 1'b0};
    vec[1]  = '{4'b1111, 1, 1'b0, 57,   0, 1'b0};
    vec[2]  = '{4'b1111, 2, 1'b0, 58,   1, 1'b0};
    vec[3]  = '{4'b1111, 3, 1'b0, 1218, 21, 1'b0};
    vec[4]  = '{4'b0101, 0, 1'b0, 1160, AVG ? 15 : 20, 1'b0};
    vec[5]  = '{4'b0101, 2, 1'b0, 116,  AVG ? 1 : 2, 1'b0};
    vec[6]  = '{4'b0101, 0, 1'b0, 580,  AVG ? 15 : 10, 1'b0};
    vec[7]  = '{4'b0101, 2, 1'b0, 116,  2, 1'b0};
    vec[8]  = '{4'b0101, 0, 1'b0, 580,  10, 1'b0};
    vec[9]  = '{4'b0101, 2, 1'b0, 0,    16'hFFFF, 1'b1};
    vec[10] = '{4'b0101, 0, 1'b0, 1740, AVG ? 20 : 30, 1'b0};
    vec[11] = '{4'b1000, 3, 1'b1, 0,    16'hFFFF, 1'b1};
    vec[12] = '{4'b1000, 3, 1'b0, 580,  10, 1'b0};
    vec[13] = '{4'b0100, 2, 1'b0, 580,  10, 1'b0};
    for (int c = 0; c < 4; c++) width[c] = 0;
    reset_p = 1'b1;
    enable = 1'b0;
    channel_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_trigger", int'(trigger), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cur_ch", int'(cur_ch), 3);
    chk("rst_dv", int'(dist_valid), 0);
    chk("rst_dist_ch", int'(dist_ch), 0);
    chk("rst_dist_cm", int'(dist_cm), 0);
    chk("rst_dist_to", int'(dist_timeout), 0);
    reset_p = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 14; i++) begin
      channel_mask = vec[i].mask;
      hold[vec[i].ch] = vec[i].hold;
      width[vec[i].ch] = vec[i].w;
      wait_dv(ok);
      chk($sformatf("vec%0d_ch", i), int'(dist_ch), vec[i].ch);
      chk($sformatf("vec%0d_cm", i), int'(dist_cm), vec[i].cm);
      chk($sformatf("vec%0d_to", i), int'(dist_timeout), int'(vec[i].to));
      chk($sformatf("vec%0d_busy", i), int'(busy), 1);
    end
    channel_mask = '0;
    repeat (300) @(negedge clk);
    chk("mask0_busy", int'(busy), 0);
    chk("mask0_trigger", int'(trigger), 0);
    t_dv = -1;
    channel_mask = 4'b1111;
    width[3] = 2000;
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      ok = trigger[3];
    end
    chk("abort_trig3_seen", int'(ok), 1);
    ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      ok = echo[3];
    end
    chk("abort_echo_seen", int'(ok), 1);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    pending = 0;
    t_dv = -1;
    @(negedge clk);
    chk("abort_trigger", int'(trigger), 0);
    chk("abort_busy", int'(busy), 0);
    ndv = 0;
    repeat (50) begin
      @(negedge clk);
      ndv += int'(dist_valid);
    end
    chk("abort_no_dv", ndv, 0);
    width[0] = 290;
    enable = 1'b1;
    wait_dv(ok);
    chk("resume_ch", int'(dist_ch), 0);
    chk("resume_cm", int'(dist_cm), AVG ? 17 : 5);
    for (int r = 0; r < 10; r++) begin
      channel_mask = 4'($urandom_range(1, 15));
      delay = $urandom_range(1, 200);
      for (int c = 0; c < 4; c++) width[c] = $urandom_range(1, 1500);
      wait_dv(ok);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
